// File: rtl/fetch_queue.sv
// Instruction fetch stage: owns the PC, reads instr_mem combinationally and buffers
// {pc, instruction} pairs in a circular FIFO feeding dispatch.
module fetch_queue #(
  parameter int          DEPTH    = 8,
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic [31:0]              imem_addr,
  input  logic [31:0]              imem_instruction,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  output logic                     deq_valid,
  input  logic                     deq_ready,
  output logic [31:0]              deq_instr,
  output logic [31:0]              deq_pc,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   pc;
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW-1:0] occ;
  logic [31:0]   mem_instr [DEPTH];
  logic [31:0]   mem_pc    [DEPTH];

  logic full;
  logic empty;
  logic enq;
  logic deq;

  assign full  = (occ == CW'(DEPTH));
  assign empty = (occ == '0);

  // enq depends only on registered occupancy, never on deq_ready
  assign enq = !redirect_valid && !full;
  assign deq = deq_valid && deq_ready;

  assign imem_addr = pc;
  assign deq_valid = !empty && !redirect_valid;
  assign deq_instr = mem_instr[head];
  assign deq_pc    = mem_pc[head];
  assign count     = occ;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc   <= RESET_PC;
      head <= '0;
      tail <= '0;
      occ  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_instr[i] <= 32'h00000013;
        mem_pc[i]    <= 32'h00000000;
      end
    end else if (redirect_valid) begin
      // flush everything and restart fetch at the word-aligned target
      pc   <= redirect_pc & 32'hFFFF_FFFC;
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else begin
      if (enq) begin
        mem_instr[tail] <= imem_instruction;
        mem_pc[tail]    <= pc;
        tail            <= tail + 1'b1;
        pc              <= pc + 32'd4;
      end
      if (deq) begin
        head <= head + 1'b1;
      end
      case ({enq, deq})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: phase table plus a scoreboard of expected
// {pc, instruction} pairs, and a second instance exercising PC wrap.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr, imem_instruction;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        deq_valid, deq_ready;
  logic [31:0] deq_instr, deq_pc;
  logic [3:0]  count;

  logic [31:0] imem_addr2, imem_instruction2;
  logic        deq_valid2;
  logic [31:0] deq_instr2, deq_pc2;
  logic [3:0]  count2;

  int checks = 0;
  int errors = 0;

  logic [63:0] sb [$];
  logic [31:0] mpc;

  always #5 clk = ~clk;

  // instr_mem model: each word is its own address with bit 8 set
  assign imem_instruction  = imem_addr | 32'h100;
  assign imem_instruction2 = imem_addr2 | 32'h100;

  fetch_queue #(.DEPTH(8), .RESET_PC(32'h00000000)) dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_instruction(imem_instruction),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .deq_valid(deq_valid),
    .deq_ready(deq_ready), .deq_instr(deq_instr), .deq_pc(deq_pc), .count(count)
  );

  fetch_queue #(.DEPTH(8), .RESET_PC(32'hFFFFFFF8)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr2), .imem_instruction(imem_instruction2),
    .redirect_valid(1'b0), .redirect_pc(32'h0), .deq_valid(deq_valid2),
    .deq_ready(1'b1), .deq_instr(deq_instr2), .deq_pc(deq_pc2), .count(count2)
  );

  typedef struct {
    bit          ready;
    bit          rv;
    logic [31:0] rpc;
    int          ncycles;
    logic [31:0] exp_count;
    logic [31:0] exp_addr;
    logic [31:0] exp_valid;
    logic [31:0] exp_pc;
  } phase_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic modelReset(input logic [31:0] rpc);
    sb.delete();
    mpc = rpc;
  endtask

  // compare combinational outputs against the model, then advance the model over the edge
  task automatic checkOutput(input bit r, input bit v, input logic [31:0] p);
    logic [63:0] head;
    bit          ev;
    bit          was_full;
    ev = (sb.size() != 0) && !v;
    chk("deq_valid", {31'b0, deq_valid}, {31'b0, ev});
    chk("count", {28'b0, count}, sb.size());
    chk("imem_addr", imem_addr, mpc);
    if (ev) begin
      head = sb[0];
      chk("deq_pc", deq_pc, head[63:32]);
      chk("deq_instr", deq_instr, head[31:0]);
    end
    if (v) begin
      sb.delete();
      mpc = {p[31:2], 2'b00};
    end else begin
      was_full = (sb.size() == 8);
      if (ev && r) void'(sb.pop_front());
      if (!was_full) begin
        sb.push_back({mpc, mpc | 32'h100});
        mpc = mpc + 32'd4;
      end
    end
  endtask

  task automatic applyStimulus(input bit r, input bit v, input logic [31:0] p);
    deq_ready      = r;
    redirect_valid = v;
    redirect_pc    = p;
    #3;
    checkOutput(r, v, p);
    @(posedge clk);
    #1;
  endtask

  initial begin
    phase_t      phases [8];
    logic [31:0] wrap_pcs [4];

    phases[0] = '{1'b0, 1'b0, 32'h0,    12, 8, 32'h20,   1, 32'h0};
    phases[1] = '{1'b1, 1'b0, 32'h0,    10, 7, 32'h44,   1, 32'h28};
    phases[2] = '{1'b0, 1'b0, 32'h0,     2, 8, 32'h48,   1, 32'h28};
    phases[3] = '{1'b1, 1'b1, 32'h1000,  1, 0, 32'h1000, 0, 32'h0};
    phases[4] = '{1'b1, 1'b0, 32'h0,     1, 1, 32'h1004, 1, 32'h1000};
    phases[5] = '{1'b1, 1'b1, 32'h2003,  1, 0, 32'h2000, 0, 32'h0};
    phases[6] = '{1'b1, 1'b0, 32'h0,     1, 1, 32'h2004, 1, 32'h2000};
    phases[7] = '{1'b0, 1'b0, 32'h0,     5, 6, 32'h2018, 1, 32'h2000};
    wrap_pcs  = '{32'hFFFFFFF8, 32'hFFFFFFFC, 32'h00000000, 32'h00000004};

    rst_n = 1'b0;
    deq_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset count", {28'b0, count}, 32'd0);
    chk("reset deq_valid", {31'b0, deq_valid}, 32'd0);
    chk("reset deq_instr", deq_instr, 32'h00000013);
    chk("reset deq_pc", deq_pc, 32'h0);
    chk("reset imem_addr", imem_addr, 32'h0);
    chk("reset wrap imem_addr", imem_addr2, 32'hFFFFFFF8);
    rst_n = 1'b1;
    modelReset(32'h0);

    foreach (phases[i]) begin
      repeat (phases[i].ncycles) applyStimulus(phases[i].ready, phases[i].rv, phases[i].rpc);
      redirect_valid = 1'b0;
      deq_ready = 1'b0;
      #1;
      chk($sformatf("phase%0d count", i), {28'b0, count}, phases[i].exp_count);
      chk($sformatf("phase%0d imem_addr", i), imem_addr, phases[i].exp_addr);
      chk($sformatf("phase%0d deq_valid", i), {31'b0, deq_valid}, phases[i].exp_valid);
      if (phases[i].exp_valid == 1) chk($sformatf("phase%0d deq_pc", i), deq_pc, phases[i].exp_pc);
    end

    // asynchronous reset mid-stream with six entries queued
    rst_n = 1'b0;
    #1;
    chk("async reset count", {28'b0, count}, 32'd0);
    chk("async reset deq_valid", {31'b0, deq_valid}, 32'd0);
    chk("async reset imem_addr", imem_addr, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    modelReset(32'h0);

    // PC wrap on the second instance while the first runs free
    for (int k = 0; k < 5; k++) begin
      if (k == 0) begin
        chk("wrap first deq_valid", {31'b0, deq_valid2}, 32'd0);
      end else begin
        chk($sformatf("wrap deq_valid %0d", k), {31'b0, deq_valid2}, 32'd1);
        chk($sformatf("wrap deq_pc %0d", k), deq_pc2, wrap_pcs[k-1]);
      end
      applyStimulus(1'b1, 1'b0, 32'h0);
    end

    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
